// File: rtl/add_sub_pkg.sv
// Shared opcodes and the reference arithmetic for the add/sub pipeline.
// The calc function works on a 32-bit container and is narrowed by the caller.
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MAX_W = 32;
    localparam int RES_W = MAX_W + 1;

    typedef struct packed {
        logic             sat;
        logic [MAX_W:0]   y;
    } calc_t;

    // Operands must already be zero above bit width-1.
    function automatic calc_t add_sub_calc(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             sub,
        input logic             sat_en,
        input int               width
    );
        logic [MAX_W:0] top_bit;
        logic [MAX_W:0] mask;
        logic [MAX_W:0] sum;
        logic [MAX_W:0] diff;
        logic           borrow;
        calc_t          r;
        top_bit = RES_W'(1) << width;
        mask    = top_bit - RES_W'(1);
        sum     = {1'b0, a} + {1'b0, b};
        diff    = ({1'b0, a} - {1'b0, b}) & mask;
        borrow  = (a < b);
        r.sat   = 1'b0;
        r.y     = '0;
        if (sub == OP_ADD) begin
            if (sat_en && (|(sum & top_bit))) begin
                r.y   = mask;
                r.sat = 1'b1;
            end else begin
                r.y = sum;
            end
        end else begin
            if (borrow && sat_en) begin
                r.y   = '0;
                r.sat = 1'b1;
            end else if (borrow) begin
                r.y = diff | top_bit;
            end else begin
                r.y = diff;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_sub_pipe_stage_reg.sv
// Delay register with valid bit; holds its contents while the pipeline is stalled.
module pipe_stage_reg #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          d_valid,
    input  logic [DW-1:0] d_data,
    output logic          q_valid,
    output logic [DW-1:0] q_data
);

    logic          valid_reg;
    logic [DW-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (!hold) begin
            valid_reg <= d_valid;
            // Bubbles leave the data untouched to avoid needless toggling.
            if (d_valid) begin
                data_reg <= d_data;
            end
        end
    end

    assign q_valid = valid_reg;
    assign q_data  = data_reg;

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined unsigned adder/subtractor: compute in stage 1, then STAGES-1 delay
// stages, with a single global stall driven by output backpressure.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int SAT_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             sat,
    output logic [CNT_W-1:0] op_count
);

    localparam int DW = WIDTH + 2;  // {sat, y}

    calc_t             calc_res;
    logic              stall;
    logic [STAGES-1:0] stage_valid;
    logic [DW-1:0]     stage_data [STAGES];

    logic              stage1_valid_reg;
    logic [DW-1:0]     stage1_data_reg;
    logic [CNT_W-1:0]  op_count_reg;

    assign calc_res = add_sub_calc(MAX_W'(a), MAX_W'(b), sub, (SAT_EN != 0), WIDTH);

    logic unused_calc;
    assign unused_calc = ^calc_res;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_valid_reg <= 1'b0;
            stage1_data_reg  <= '0;
        end else if (!stall) begin
            stage1_valid_reg <= in_valid;
            if (in_valid) begin
                stage1_data_reg <= {calc_res.sat, calc_res.y[WIDTH:0]};
            end
        end
    end

    assign stage_valid[0] = stage1_valid_reg;
    assign stage_data[0]  = stage1_data_reg;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_delay
            pipe_stage_reg #(
                .DW(DW)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .hold    (stall),
                .d_valid (stage_valid[gi-1]),
                .d_data  (stage_data[gi-1]),
                .q_valid (stage_valid[gi]),
                .q_data  (stage_data[gi])
            );
        end
    endgenerate

    assign out_valid = stage_valid[STAGES-1];
    assign y         = stage_data[STAGES-1][WIDTH:0];
    assign sat       = stage_data[STAGES-1][WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (out_valid && out_ready) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign op_count = op_count_reg;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: wrap, saturating, and 16-bit 1/4-stage instances.
module tb_add_sub_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit wrap, 2 stages
    logic       wa_in_valid = 0, wa_in_ready, wa_sub = 0, wa_out_valid, wa_out_ready = 1, wa_sat;
    logic [7:0] wa_a = 0, wa_b = 0;
    logic [8:0] wa_y;
    logic [15:0] wa_cnt;
    // 8-bit saturating, 2 stages
    logic       sa_in_valid = 0, sa_in_ready, sa_sub = 0, sa_out_valid, sa_out_ready = 1, sa_sat;
    logic [7:0] sa_a = 0, sa_b = 0;
    logic [8:0] sa_y;
    logic [15:0] sa_cnt;
    // 16-bit, 1 stage and 4 stages
    logic        c1_in_valid = 0, c1_in_ready, c1_out_valid, c1_sat;
    logic        c4_in_valid = 0, c4_in_ready, c4_out_valid, c4_sat;
    logic [15:0] c_a = 0, c_b = 0;
    logic [16:0] c1_y, c4_y;
    logic [15:0] c1_cnt, c4_cnt;

    add_sub_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(0), .CNT_W(16)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(wa_in_valid), .in_ready(wa_in_ready),
        .a(wa_a), .b(wa_b), .sub(wa_sub), .out_valid(wa_out_valid), .out_ready(wa_out_ready),
        .y(wa_y), .sat(wa_sat), .op_count(wa_cnt));

    add_sub_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(1), .CNT_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(sa_in_valid), .in_ready(sa_in_ready),
        .a(sa_a), .b(sa_b), .sub(sa_sub), .out_valid(sa_out_valid), .out_ready(sa_out_ready),
        .y(sa_y), .sat(sa_sat), .op_count(sa_cnt));

    add_sub_pipe #(.WIDTH(16), .STAGES(1), .SAT_EN(0), .CNT_W(16)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
        .a(c_a), .b(c_b), .sub(1'b0), .out_valid(c1_out_valid), .out_ready(1'b1),
        .y(c1_y), .sat(c1_sat), .op_count(c1_cnt));

    add_sub_pipe #(.WIDTH(16), .STAGES(4), .SAT_EN(0), .CNT_W(16)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
        .a(c_a), .b(c_b), .sub(1'b0), .out_valid(c4_out_valid), .out_ready(1'b1),
        .y(c4_y), .sat(c4_sat), .op_count(c4_cnt));

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        string      name;
        bit         sat_mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [8:0] exp_y;
        logic       exp_sat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic       got;
        logic       seen;
        logic [8:0] act_y;
        logic       act_sat;
        logic [8:0] exp_q[$];
        logic [8:0] exp_head;
        logic [8:0] prev_y;
        logic       prev_stall;
        int         k;
        int         received;

        vecs[0]  = '{"wrap_ff_plus_01",  0, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        vecs[1]  = '{"wrap_05_minus_07", 0, 8'h05, 8'h07, 1'b1, 9'h1FE, 1'b0};
        vecs[2]  = '{"wrap_07_minus_07", 0, 8'h07, 8'h07, 1'b1, 9'h000, 1'b0};
        vecs[3]  = '{"wrap_ff_plus_ff",  0, 8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0};
        vecs[4]  = '{"wrap_10_plus_20",  0, 8'h10, 8'h20, 1'b0, 9'h030, 1'b0};
        vecs[5]  = '{"sat_f0_plus_20",   1, 8'hF0, 8'h20, 1'b0, 9'h0FF, 1'b1};
        vecs[6]  = '{"sat_03_minus_09",  1, 8'h03, 8'h09, 1'b1, 9'h000, 1'b1};
        vecs[7]  = '{"sat_10_plus_20",   1, 8'h10, 8'h20, 1'b0, 9'h030, 1'b0};
        vecs[8]  = '{"sat_ff_plus_ff",   1, 8'hFF, 8'hFF, 1'b0, 9'h0FF, 1'b1};
        vecs[9]  = '{"sat_07_minus_07",  1, 8'h07, 8'h07, 1'b1, 9'h000, 1'b0};
        vecs[10] = '{"sat_09_minus_03",  1, 8'h09, 8'h03, 1'b1, 9'h006, 1'b0};

        // Reset state
        tick();
        check("rst_out_valid", 32'(wa_out_valid), 32'd0);
        check("rst_y", 32'(wa_y), 32'd0);
        check("rst_sat", 32'(wa_sat), 32'd0);
        check("rst_op_count", 32'(wa_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(wa_in_ready), 32'd1);
        tick();

        // Table-driven single operations
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].sat_mode) begin
                sa_a = vecs[i].a; sa_b = vecs[i].b; sa_sub = vecs[i].sub; sa_in_valid = 1'b1;
            end else begin
                wa_a = vecs[i].a; wa_b = vecs[i].b; wa_sub = vecs[i].sub; wa_in_valid = 1'b1;
            end
            tick();
            sa_in_valid = 1'b0;
            wa_in_valid = 1'b0;
            got = 1'b0;
            act_y = '0;
            act_sat = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (vecs[i].sat_mode ? sa_out_valid : wa_out_valid) begin
                    got = 1'b1;
                    act_y = vecs[i].sat_mode ? sa_y : wa_y;
                    act_sat = vecs[i].sat_mode ? sa_sat : wa_sat;
                end
            end
            check({vecs[i].name, "_timeout"}, 32'(got), 32'd1);
            check({vecs[i].name, "_y"}, 32'(act_y), 32'(vecs[i].exp_y));
            check({vecs[i].name, "_sat"}, 32'(act_sat), 32'(vecs[i].exp_sat));
            $display("vec %s: a=%0h b=%0h sub=%0d y=%0h sat=%0d", vecs[i].name,
                     vecs[i].a, vecs[i].b, vecs[i].sub, act_y, act_sat);
        end
        tick();

        // Reset with data in flight
        for (int i = 0; i < 3; i++) begin
            wa_a = 8'(i + 1); wa_b = 8'd1; wa_sub = 1'b0; wa_in_valid = 1'b1;
            tick();
        end
        wa_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(wa_out_valid), 32'd0);
        check("midrst_y", 32'(wa_y), 32'd0);
        check("midrst_op_count", 32'(wa_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (wa_out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);

        // Streaming throughput and latency
        do_reset();
        for (int cyc = 0; cyc < 27; cyc++) begin
            if (cyc < 25) begin
                wa_a = 8'(cyc); wa_b = 8'(cyc); wa_sub = 1'b0; wa_in_valid = 1'b1;
            end else begin
                wa_in_valid = 1'b0;
            end
            tick();
            if (cyc == 0) begin
                check("stream_first_latency", 32'(wa_out_valid), 32'd0);
            end else if (cyc <= 25) begin
                check("stream_valid", 32'(wa_out_valid), 32'd1);
                check("stream_y", 32'(wa_y), 32'(2 * (cyc - 1)));
                $display("stream i=%0d y=%0h", cyc - 1, wa_y);
            end
        end
        check("stream_op_count", 32'(wa_cnt), 32'd25);

        // Backpressure with out_ready pattern 1,0,0,1
        do_reset();
        k = 0;
        received = 0;
        prev_stall = 1'b0;
        prev_y = '0;
        for (int cyc = 0; cyc < 80 && received < 10; cyc++) begin
            wa_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (k < 10) begin
                wa_a = 8'(k * 3 + 1); wa_b = 8'(k * 5); wa_sub = 1'b0; wa_in_valid = 1'b1;
            end else begin
                wa_in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(wa_in_ready), 32'(!(wa_out_valid && !wa_out_ready)));
            if (prev_stall) begin
                check("bp_hold_valid", 32'(wa_out_valid), 32'd1);
                check("bp_hold_y", 32'(wa_y), 32'(prev_y));
            end
            if (wa_out_valid && wa_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_result", 32'(wa_y), 32'h1000);
                end else begin
                    exp_head = exp_q.pop_front();
                    check("bp_result", 32'(wa_y), 32'(exp_head));
                    $display("bp result %0d y=%0h", received, wa_y);
                end
                received++;
            end
            prev_stall = wa_out_valid && !wa_out_ready;
            prev_y = wa_y;
            if (wa_in_valid && wa_in_ready) begin
                exp_q.push_back(9'(k * 3 + 1) + 9'(k * 5));
                k++;
            end
            tick();
        end
        wa_in_valid = 1'b0;
        wa_out_ready = 1'b1;
        check("bp_received", 32'(received), 32'd10);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bp_op_count", 32'(wa_cnt), 32'd10);

        // 16-bit latency sweep: STAGES=1 and STAGES=4
        do_reset();
        c_a = 16'hFFFF; c_b = 16'hFFFF;
        c1_in_valid = 1'b1; c4_in_valid = 1'b1;
        #1;
        check("s1_pre_valid", 32'(c1_out_valid), 32'd0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            c1_in_valid = 1'b0; c4_in_valid = 1'b0;
            check("s1_valid", 32'(c1_out_valid), 32'(e == 1));
            if (e == 1) check("s1_y", 32'(c1_y), 32'h1FFFE);
            check("s4_valid", 32'(c4_out_valid), 32'(e == 4));
            if (e == 4) check("s4_y", 32'(c4_y), 32'h1FFFE);
            $display("sweep edge %0d: s1 v=%0d y=%0h s4 v=%0d y=%0h", e,
                     c1_out_valid, c1_y, c4_out_valid, c4_y);
        end
        tick();
        check("s4_op_count", 32'(c4_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined unsigned adder/subtractor with valid/ready handshakes on input and output.
- Next generation of the team's 8-bit combinational adder: configurable width, pipeline depth and saturation mode, plus backpressure and an operation counter.
- Sits between a stimulus/data source and a result sink.
- Directly drivable from file-driven benches that feed a/b/expected triples.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..32).
- STAGES, 2, pipeline depth in register stages (legal 1..4).
- SAT_EN, 0, 1 = saturating arithmetic, 0 = wrap with carry/borrow bit.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b/sub are valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  y/sat are valid.
- out_ready  input  1  sink accepts the result this cycle.
- y  output  WIDTH+1  result; MSB is carry (add) or borrow (sub) in wrap mode.
- sat  output  1  result was clamped (SAT_EN=1 only; 0 otherwise).
- op_count  output  CNT_W  number of results delivered since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits = 0; out_valid = 0; y = 0; sat = 0; op_count = 0.
  - in_ready = 1 combinationally once rst_n is high.
  - Reset mid-operation discards all in-flight data; no partial result is ever presented.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - y and sat are held stable while out_valid && !out_ready.
- Stall: global stall = out_valid && !out_ready.
  - While stalled, every stage holds and in_ready = 0.
  - Otherwise all stages advance and in_ready = 1.
  - in_ready must not depend on in_valid.
- Latency: an operand set accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES cycles of registering including the output register, when unstalled.
- Throughput: one result per cycle when out_ready stays high.
- Bubbles (invalid stages) propagate as invalid. No bubble collapsing is required.
- Wrap mode (SAT_EN = 0):
  - add: y = a + b, full WIDTH+1 bits.
  - sub: y[WIDTH-1:0] = (a - b) mod 2^WIDTH; y[WIDTH] = 1 if a < b.
  - sat = 0.
- Saturating mode (SAT_EN = 1):
  - add overflow: y = {1'b0, all-ones(WIDTH)}, sat = 1.
  - sub with a < b: y = 0, sat = 1.
  - otherwise the wrap-mode result with y[WIDTH] = 0 and sat = 0.
- Compute placement: arithmetic is computed in stage 1. Stages 2..STAGES are pure delay registers carrying {valid, y, sat}.
- op_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured. The pipeline advances and the new entry enters stage 1.
- Edge cases:
  - a = b under subtraction gives 0 with no borrow.
  - All-ones plus all-ones gives carry = 1 in wrap mode and saturates in sat mode.
  - STAGES = 1 means the stage-1 register is the output register.

Decomposition:
- Shared package add_sub_pkg holds:
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - a function computing {result, sat} from a, b, sub, SAT_EN, reused by the bench's reference model.
- One natural sub-module, pipe_stage_reg: a parametrised-width register with valid bit and hold (stall) enable. It is instantiated STAGES-1 times by a generate loop after the compute stage.

Test Plan:
- Reset with in-flight data: drive 3 valid adds, then assert rst_n low mid-stream -> out_valid = 0, y = 0 and op_count = 0 immediately (asynchronously); no result emerges after release.
- WIDTH = 8, STAGES = 2, SAT_EN = 0, out_ready = 1, stream i = 0..24 with a = i, b = i, sub = 0 -> y = 2*i, each result 2 cycles after its input; op_count = 25 at the end.
- Wrap boundaries, WIDTH = 8:
  - 0xFF + 0x01 -> y = 0x100.
  - 0x05 - 0x07 -> y = 0x1FE (borrow set).
  - 0x07 - 0x07 -> y = 0x000.
- SAT_EN = 1, WIDTH = 8:
  - 0xF0 + 0x20 -> y = 0x0FF, sat = 1.
  - 0x03 - 0x09 -> y = 0x000, sat = 1.
  - 0x10 + 0x20 -> y = 0x030, sat = 0.
- Backpressure: stream 10 adds while out_ready toggles 1,0,0,1,... -> in_ready low exactly when out_valid && !out_ready; y stays stable while stalled; all 10 results arrive in order with none dropped or duplicated; op_count = 10.
- Parameter sweep: WIDTH = 16 with STAGES = 1 and STAGES = 4, 0xFFFF + 0xFFFF -> y = 0x1FFFE, with latency of 1 and 4 cycles respectively.
